// File: rtl/dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_pkg                                                              |
// | Shared constants and types for the DMA read engine.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dma_pkg;

    localparam int CL_BYTE_OFFSET = 6;
    localparam int SIZE_WIDTH_DEF = 59;

    typedef logic [SIZE_WIDTH_DEF-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dma_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_fifo                                                             |
// | Show-ahead FIFO with occupancy count; head reads zero while empty.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dma_fifo
    import dma_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]   count_q, count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign w_do_push = push && (count_q != c_FULL_CNT);
    assign w_do_pop  = pop && !empty;
    // Zero head while empty keeps the output deterministic after a flush.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + c_PTR_W'(w_do_push);
        rd_ptr_d = rd_ptr_q + c_PTR_W'(w_do_pop);
        count_d  = count_q + (c_PTR_W+1)'(w_do_push) - (c_PTR_W+1)'(w_do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_rd_engine                                                        |
// | Issues cache-line reads for a transfer and buffers in-order replies. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dma_rd_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 59,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic [SIZE_WIDTH-1:0]                rd_size,
    input  logic                                 rd_go,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 empty,
    output logic                                 rd_done,
    output logic                                 mem_req_valid,
    output logic [ADDR_WIDTH-CL_BYTE_OFFSET-1:0] mem_req_addr,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                mem_rsp_data
);

    localparam int c_LINE_W = ADDR_WIDTH - CL_BYTE_OFFSET;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W+1)'(FIFO_DEPTH);

    state_t                 state_q, state_d;
    logic [c_LINE_W-1:0]    line_addr_q, line_addr_d;
    logic [SIZE_WIDTH-1:0]  size_q, size_d;
    logic [SIZE_WIDTH-1:0]  req_cnt_q, req_cnt_d;
    logic [SIZE_WIDTH-1:0]  cons_cnt_q, cons_cnt_d;
    logic [c_CNT_W-1:0]     outstanding_q, outstanding_d;
    logic                   rd_done_q, rd_done_d;

    logic [c_CNT_W-1:0]     w_fifo_count;
    logic [c_CNT_W:0]       w_credit_used;
    logic                   w_go;
    logic                   w_req_fire;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_unused_addr_bits;

    assign w_unused_addr_bits = ^rd_addr[CL_BYTE_OFFSET-1:0];

    // Lines in flight plus lines buffered never exceed the FIFO depth.
    assign w_credit_used = {1'b0, outstanding_q} + {1'b0, w_fifo_count};
    assign mem_req_valid = (state_q == REQ) && (req_cnt_q < size_q)
                           && (w_credit_used < c_DEPTH_EXT);
    assign mem_req_addr  = line_addr_q;
    assign rd_done       = rd_done_q;

    assign w_go       = rd_go && ((state_q == IDLE) || (state_q == DONE));
    assign w_req_fire = mem_req_valid && mem_req_ready;
    assign w_push     = mem_rsp_valid && (outstanding_q != '0);
    assign w_pop      = rd_en && !empty;

    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        size_d        = size_q;
        req_cnt_d     = req_cnt_q;
        cons_cnt_d    = cons_cnt_q;
        outstanding_d = outstanding_q + c_CNT_W'(w_req_fire) - c_CNT_W'(w_push);

        if (w_go) begin
            line_addr_d = rd_addr[ADDR_WIDTH-1:CL_BYTE_OFFSET];
            size_d      = rd_size;
            req_cnt_d   = '0;
            cons_cnt_d  = '0;
            state_d     = (rd_size == '0) ? DONE : REQ;
        end else begin
            if (w_req_fire) begin
                line_addr_d = line_addr_q + c_LINE_W'(1);
                req_cnt_d   = req_cnt_q + SIZE_WIDTH'(1);
                if (req_cnt_d == size_q) begin
                    state_d = DRAIN;
                end
            end
            if (w_pop) begin
                cons_cnt_d = cons_cnt_q + SIZE_WIDTH'(1);
            end
            // Completion follows the final pop edge directly.
            if (((state_q == REQ) || (state_q == DRAIN)) && (cons_cnt_d == size_q)) begin
                state_d = DONE;
            end
        end

        rd_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            line_addr_q   <= '0;
            size_q        <= '0;
            req_cnt_q     <= '0;
            cons_cnt_q    <= '0;
            outstanding_q <= '0;
            rd_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_addr_q   <= line_addr_d;
            size_q        <= size_d;
            req_cnt_q     <= req_cnt_d;
            cons_cnt_q    <= cons_cnt_d;
            outstanding_q <= outstanding_d;
            rd_done_q     <= rd_done_d;
        end
    end

    dma_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (mem_rsp_data),
        .pop       (w_pop),
        .head_data (rd_data),
        .empty     (empty),
        .count     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dma_rd_engine                                                     |
// | Directed bench with a 2-cycle in-order memory responder.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dma_rd_engine;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   rd_addr;
    logic [58:0]   rd_size;
    logic          rd_go;
    logic          rd_en;
    logic [511:0]  rd_data;
    logic          empty;
    logic          rd_done;
    logic          mem_req_valid;
    logic [57:0]   mem_req_addr;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [511:0]  mem_rsp_data;

    typedef struct {
        logic [57:0] addr;
        int          due;
    } pend_t;

    pend_t        pend_q[$];
    logic [57:0]  req_log[$];
    int           req_total = 0;
    int           rsp_cyc   = 0;
    logic         rsp_hold  = 1'b0;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           base;
    int           got;
    int           cyc;
    int           wait_b;
    logic         stalled;
    logic [57:0]  prev_addr;

    always #5 clk = ~clk;

    dma_rd_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr       (rd_addr),
        .rd_size       (rd_size),
        .rd_go         (rd_go),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .rd_done       (rd_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    function automatic logic [511:0] line_data(input logic [57:0] la);
        return {8{6'h15, la}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [63:0] addr, input logic [58:0] size);
        rd_addr = addr;
        rd_size = size;
        rd_go   = 1'b1;
        @(negedge clk);
        rd_go   = 1'b0;
    endtask

    // Pops n lines whenever data is shown, checking each against its line address.
    task automatic pop_lines(input string tag, input logic [57:0] first, input int n, input int budget);
        int g = 0;
        int c = 0;
        while (g < n && c < budget) begin
            if (!empty) begin
                check({tag, "_data"}, rd_data, line_data(first + 58'(g)));
                rd_en = 1'b1;
                g++;
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        rd_en = 1'b0;
        check({tag, "_popcount"}, 512'(g), 512'(n));
    endtask

    // Memory model: requests seen at the negedge fire at the next posedge; reply two cycles later.
    initial begin : responder
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            rsp_cyc++;
            if (!rsp_hold && pend_q.size() > 0 && pend_q[0].due <= rsp_cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = line_data(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                pend_q.push_back('{addr: mem_req_addr, due: rsp_cyc + 2});
                req_log.push_back(mem_req_addr);
                req_total++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n         = 1'b0;
        rd_addr       = '0;
        rd_size       = '0;
        rd_go         = 1'b0;
        rd_en         = 1'b0;
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_empty", 512'(empty), 512'(1));
        check("rst_done", 512'(rd_done), 512'(0));
        check("rst_valid", 512'(mem_req_valid), 512'(0));
        check("rst_data", rd_data, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 4-line transfer from 0x1000.
        mem_req_ready = 1'b1;
        base = req_total;
        go(64'h1000, 59'd4);
        check("t1_first_valid", 512'(mem_req_valid), 512'(1));
        check("t1_first_addr", 512'(mem_req_addr), 512'h40);
        pop_lines("t1", 58'h40, 4, 100);
        check("t1_done", 512'(rd_done), 512'(1));
        check("t1_nreq", 512'(req_total - base), 512'(4));
        for (int i = 0; i < 4; i++) check("t1_addr_seq", 512'(req_log[base + i]), 512'(58'h40 + 58'(i)));
        check("t1_empty", 512'(empty), 512'(1));

        // 40 lines with no consumer: credit stalls after 16.
        base = req_total;
        go(64'h2000, 59'd40);
        check("t2_done_clear", 512'(rd_done), 512'(0));
        repeat (40) @(negedge clk);
        check("t2_stall_nreq", 512'(req_total - base), 512'(16));
        check("t2_stall_valid", 512'(mem_req_valid), 512'(0));
        check("t2_not_empty", 512'(empty), 512'(0));
        pop_lines("t2", 58'h80, 40, 600);
        check("t2_done", 512'(rd_done), 512'(1));
        check("t2_nreq", 512'(req_total - base), 512'(40));

        // Zero-length transfer; pops while empty must do nothing.
        base = req_total;
        go(64'h3000, 59'd0);
        check("t3_done", 512'(rd_done), 512'(1));
        check("t3_valid", 512'(mem_req_valid), 512'(0));
        rd_en = 1'b1;
        repeat (4) @(negedge clk);
        rd_en = 1'b0;
        check("t3_empty", 512'(empty), 512'(1));
        check("t3_done_hold", 512'(rd_done), 512'(1));
        check("t3_nreq", 512'(req_total - base), 512'(0));

        // Line address wrap at the top of the address space.
        base = req_total;
        go(64'hFFFF_FFFF_FFFF_FFC0, 59'd3);
        check("t4_done_clear", 512'(rd_done), 512'(0));
        check("t4_first_addr", 512'(mem_req_addr), 512'h3FF_FFFF_FFFF_FFFF);
        pop_lines("t4", 58'h3FF_FFFF_FFFF_FFFF, 3, 100);
        check("t4_done", 512'(rd_done), 512'(1));
        check("t4_addr0", 512'(req_log[base]), 512'h3FF_FFFF_FFFF_FFFF);
        check("t4_addr1", 512'(req_log[base + 1]), 512'h0);
        check("t4_addr2", 512'(req_log[base + 2]), 512'h1);

        // Reset with 5 of 10 requests issued, 3 still outstanding.
        base = req_total;
        go(64'h5000, 59'd10);
        wait_b = 0;
        while ((req_total - base) < 2 && wait_b < 20) begin @(negedge clk); wait_b++; end
        mem_req_ready = 1'b0;
        repeat (4) @(negedge clk);
        rsp_hold = 1'b1;
        mem_req_ready = 1'b1;
        wait_b = 0;
        while ((req_total - base) < 5 && wait_b < 20) begin @(negedge clk); wait_b++; end
        mem_req_ready = 1'b0;
        check("t5_nreq_pre", 512'(req_total - base), 512'(5));
        check("t5_pend_pre", 512'(pend_q.size()), 512'(3));
        check("t5_buffered_pre", 512'(empty), 512'(0));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_empty", 512'(empty), 512'(1));
        check("t5_rst_data", rd_data, '0);
        rst_n    = 1'b1;
        rsp_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_stray_empty", 512'(empty), 512'(1));
        end
        check("t5_valid", 512'(mem_req_valid), 512'(0));
        check("t5_done", 512'(rd_done), 512'(0));
        mem_req_ready = 1'b1;
        base = req_total;
        go(64'h6000, 59'd2);
        pop_lines("t5_after", 58'h180, 2, 100);
        check("t5_after_done", 512'(rd_done), 512'(1));
        check("t5_after_nreq", 512'(req_total - base), 512'(2));

        // Random backpressure with an ignored rd_go mid-transfer.
        mem_req_ready = 1'b0;
        base = req_total;
        go(64'h7000, 59'd12);
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_addr = '0;
        while (got < 12 && cyc < 400) begin
            if (stalled) check("t6_addr_hold", 512'(mem_req_addr), 512'(prev_addr));
            if (cyc == 3) begin
                rd_go   = 1'b1;
                rd_addr = 64'hABC000;
                rd_size = 59'd5;
            end else begin
                rd_go = 1'b0;
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            stalled   = mem_req_valid && !mem_req_ready;
            prev_addr = mem_req_addr;
            if (!empty) begin
                check("t6_data", rd_data, line_data(58'h1C0 + 58'(got)));
                rd_en = 1'b1;
                got++;
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rd_en = 1'b0;
        rd_go = 1'b0;
        check("t6_popcount", 512'(got), 512'(12));
        check("t6_done", 512'(rd_done), 512'(1));
        check("t6_nreq", 512'(req_total - base), 512'(12));
        for (int i = 0; i < 12; i++) check("t6_addr_seq", 512'(req_log[base + i]), 512'(58'h1C0 + 58'(i)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_rd_engine.md
DMA_RD_ENGINE -- requirements
Module: dma_rd_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, SHALL set the virtual byte address width.
REQ-002 Parameter DATA_WIDTH, default 512, SHALL set the cache-line data width.
REQ-003 Parameter SIZE_WIDTH, default 59, SHALL set the transfer size width, in cache lines.
REQ-004 Parameter FIFO_DEPTH, default 16 (power of 2, >=2), SHALL set the read buffer depth.
REQ-005 clk  in  1: the single clock; all logic SHALL be rising-edge.
REQ-006 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-007 rd_addr  in  ADDR_WIDTH: starting virtual byte address, 64B-aligned.
REQ-008 rd_size  in  SIZE_WIDTH: number of lines to read.
REQ-009 rd_go  in  1: start pulse.
REQ-010 rd_en  in  1: consumer pop.
REQ-011 rd_data  out  DATA_WIDTH: FIFO head, show-ahead.
REQ-012 empty  out  1: high when no line is buffered.
REQ-013 rd_done  out  1: high after rd_size lines have been popped.
REQ-014 mem_req_valid  out  1: memory read request valid.
REQ-015 mem_req_addr  out  ADDR_WIDTH-6: cache-line address.
REQ-016 mem_req_ready  in  1: memory accepts request.
REQ-017 mem_rsp_valid  in  1: in-order read response valid.
REQ-018 mem_rsp_data  in  DATA_WIDTH: response line.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DRAIN and DONE.
REQ-020 rd_go SHALL be accepted in IDLE or DONE and ignored in REQ or DRAIN.
REQ-021 On accept: latch line address rd_addr[ADDR_WIDTH-1:6]; latch rd_size; clear the request/consume counters; deassert rd_done next cycle; enter REQ (DONE if rd_size==0).
REQ-022 In REQ, mem_req_valid SHALL be high iff req_count<size and (outstanding+fifo_count)<FIFO_DEPTH.
REQ-023 A request SHALL be accepted on mem_req_valid&mem_req_ready; the address and req_count then increment by 1.
REQ-024 While mem_req_valid is high and mem_req_ready is low, mem_req_addr SHALL be held stable.
REQ-025 Line address increment SHALL wrap modulo 2^(ADDR_WIDTH-6).
REQ-026 Acceptance of the last request SHALL move the FSM to DRAIN the next cycle.
REQ-027 mem_rsp_valid with outstanding>0 SHALL push mem_rsp_data and decrement outstanding; with outstanding==0 it SHALL be dropped.
REQ-028 Credit accounting SHALL guarantee the FIFO never overflows, including same-cycle accept, response and pop.
REQ-029 rd_en with !empty SHALL pop the head and increment consume_count; rd_en while empty SHALL be ignored.
REQ-030 Push into an empty FIFO SHALL make data visible (empty=0) on the next cycle.
REQ-031 In REQ or DRAIN, consume_count==size SHALL enter DONE the next cycle; rd_done=1 in DONE, held until the next accepted rd_go.
REQ-032 Minimum go-to-first-request latency SHALL be 1 cycle.

Reset
REQ-033 On rst_n low: state IDLE, counters 0, FIFO flushed, mem_req_valid=0, rd_done=0, empty=1, rd_data=0.
REQ-034 Reset mid-transfer SHALL abandon the transfer; post-reset stray responses are dropped per REQ-027.

Structure
REQ-035 Package dma_pkg SHALL hold: CL_BYTE_OFFSET=6, state enum state_t, typedef count_t [SIZE_WIDTH-1:0].
REQ-036 Buffering SHALL be one sub-module, dma_fifo (show-ahead, parameterized width/depth, count output, async active-low reset).
REQ-037 Implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-038 rd_addr=0x1000, rd_size=4, ready=1, 2-cycle response delay, rd_en whenever !empty -> requests 0x40..0x43; data in order; rd_done=1 one cycle after the 4th pop.
REQ-039 rd_size=40, rd_en held low -> exactly 16 requests issued and then stalled; after 40 pops, 40 requests total and rd_done=1.
REQ-040 rd_size=0 -> no mem_req_valid; rd_done=1 one cycle after rd_go.
REQ-041 rd_addr=0xFFFF_FFFF_FFFF_FFC0, rd_size=3 -> mem_req_addr sequence 0x3FF_FFFF_FFFF_FFFF, 0x0, 0x1.
REQ-042 rst_n pulled low after 5 of 10 requests with 3 outstanding, then released, then 3 stray responses -> empty stays 1; next rd_go runs cleanly.
REQ-043 mem_req_ready toggled randomly plus rd_go pulsed during REQ -> address stable while stalled; rd_go ignored; all lines delivered once, in order.
